sdram_burst_responder: RTL

Avalon-MM burst-read responder: the slave end of the frame reader's `to_sdram_*` master port. It accepts pipelined burst read commands, queues them, and streams words from an internal word-addressed frame memory with no gaps within or between queued bursts. A separate single-word write port lets the Nios-side loader fill the memory. Used as an on-chip SDRAM stand-in for VGA bring-up, and as the reference responder in the frame-reader bench.

---
 rtl/sdram_burst_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sdram_burst_responder.sv
// Avalon-MM burst-read responder backed by an on-chip word memory.
// Queued burst commands are streamed back-to-back; a loader port fills the memory.
module sdram_burst_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned CMD_DEPTH  = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [31:0]           address,
  input  logic [5:0]            burstcount,
  input  logic                  read,
  output logic                  waitrequest,
  output logic [31:0]           readdata,
  output logic                  readdatavalid,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  output logic [15:0]           bursts_done
);

  localparam int unsigned QW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned LW = 6;
  localparam logic [QW:0]    QFULL   = (QW+1)'(CMD_DEPTH);
  localparam logic [LW-1:0]  MAX_LEN = LW'(32);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  logic [31:0]           r_mem   [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] r_q_idx [CMD_DEPTH];
  logic [LW-1:0]         r_q_len [CMD_DEPTH];
  logic [QW-1:0]         r_wptr;
  logic [QW-1:0]         r_rptr;
  logic [QW:0]           r_occ;
  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_ptr;
  logic [LW-1:0]         r_left;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_last;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [LW-1:0]         w_len;
  logic [DEPTH_LOG2-1:0] w_head_idx;
  logic [LW-1:0]         w_head_len;
  logic                  w_unused_addr;

  assign w_idx         = address[DEPTH_LOG2+1:2];
  assign w_unused_addr = ^{address[31:DEPTH_LOG2+2], address[1:0]};
  assign w_len         = (burstcount > MAX_LEN) ? MAX_LEN : burstcount;
  assign waitrequest   = reset_reset | (r_occ == QFULL);
  assign w_push        = read & ~waitrequest;
  assign w_empty       = (r_occ == '0);
  assign w_head_idx    = r_q_idx[r_rptr];
  assign w_head_len    = r_q_len[r_rptr];
  assign w_last        = (r_state == S_BURST) && (r_left == LW'(1));
  // Pop whenever the engine is free to take the next command, including zero-length ones.
  assign w_pop         = ~w_empty & ((r_state == S_IDLE) | w_last);

  // Loader writes; memory contents survive reset.
  always_ff @(posedge clk_clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_clk) begin
    if (w_push) begin
      r_q_idx[r_wptr] <= w_idx;
      r_q_len[r_wptr] <= w_len;
    end
  end

  // Command queue pointers and occupancy.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + QW'(1);
      if (w_pop)  r_rptr <= r_rptr + QW'(1);
      r_occ <= r_occ + (QW+1)'(w_push) - (QW+1)'(w_pop);
    end
  end

  // Burst engine: one memory read per cycle, reloading from the queue without a bubble.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state       <= S_IDLE;
      r_ptr         <= '0;
      r_left        <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
      bursts_done   <= '0;
    end else begin
      readdatavalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty && (w_head_len != '0)) begin
            r_ptr   <= w_head_idx;
            r_left  <= w_head_len;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          readdata      <= r_mem[r_ptr];
          readdatavalid <= 1'b1;
          r_ptr         <= r_ptr + DEPTH_LOG2'(1);
          r_left        <= r_left - LW'(1);
          if (w_last) begin
            bursts_done <= bursts_done + 16'd1;
            if (!w_empty && (w_head_len != '0)) begin
              r_ptr  <= w_head_idx;
              r_left <= w_head_len;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
